// File: rtl/nibble_deinterleaver_pkg.sv
// Shared types and helpers for the nibble de-interleaver.
// Lane geometry, the receive phase encoding, the drop-counter width and
// the per-lane bit reconstruction used by the top level.
package nibble_deinterleaver_pkg;

  localparam int LANE_W     = 4;
  localparam int DROP_CNT_W = 8;

  typedef enum logic {
    PH0 = 1'b0,  // expecting beat0 of a pair
    PH1 = 1'b1   // beat0 held, expecting beat1
  } phase_e;

  // Undo the transmit interleave for one lane.
  // The transmitter sends beat0 = {A[0],B[2],A[1],B[3]} and
  // beat1 = {A[2],B[0],A[3],B[1]}; the result is packed as {A, B}.
  function automatic logic [2*LANE_W-1:0] deint_lane(
    input logic [LANE_W-1:0] n0,
    input logic [LANE_W-1:0] n1
  );
    logic [LANE_W-1:0] a;
    logic [LANE_W-1:0] b;
    a = {n1[1], n1[3], n0[1], n0[3]};
    b = {n0[0], n0[2], n1[0], n1[2]};
    return {a, b};
  endfunction

endpackage

// File: rtl/nibble_deinterleaver_fifo2.sv
// Two-entry synchronous FIFO with registered full/empty flags.
// Storage is cleared on reset so the head reads zero until the first push.
// A push while full is ignored unless a pop happens in the same cycle;
// a pop while empty is ignored.
module nibble_deinterleaver_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic [1:0]   cnt_nxt;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign cnt_nxt = cnt + {1'b0, do_push} - {1'b0, do_pop};

  assign pop_data = mem[rd_ptr];

  // Storage, pointers and the occupancy flags registered from the next count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == 2'd2);
      empty <= (cnt_nxt == 2'd0);
    end
  end

endmodule

// File: rtl/nibble_deinterleaver.sv
// Receive-side inverse of the 4-bit bit-interleaver.
// Collects beat0/beat1 over a valid/ready stream, rebuilds the A/B operand
// pair for every lane and hands it to the consumer through a 2-entry buffer.
// A beat that cannot form a pair (orphan beat1, or a beat0 displaced by a
// new beat0) is discarded and counted in the saturating drop_cnt.
// Optional build macro: NIBBLE_DEINTERLEAVER_PARITY_EN adds s_par (even
// parity of s_data per beat) and m_perr (set when either beat of the
// delivered pair had bad parity).
module nibble_deinterleaver
  import nibble_deinterleaver_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_first,
  input  logic [LANE_W*LANES-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [LANE_W*LANES-1:0] m_a,
  output logic [LANE_W*LANES-1:0] m_b,
  output logic [DROP_CNT_W-1:0]   drop_cnt
`ifdef NIBBLE_DEINTERLEAVER_PARITY_EN
  ,
  input  logic                    s_par,
  output logic                    m_perr
`endif
);

  localparam int DATA_W = LANE_W * LANES;
`ifdef NIBBLE_DEINTERLEAVER_PARITY_EN
  localparam int ENTRY_W = 2 * DATA_W + 1;
`else
  localparam int ENTRY_W = 2 * DATA_W;
`endif

  // Saturating increment for the drop counter: holds at all-ones.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  phase_e              state;
  logic [DATA_W-1:0]   hold;
  logic                ready_en;
  logic                accept;
  logic                drop_beat;
  logic [DATA_W-1:0]   pair_a;
  logic [DATA_W-1:0]   pair_b;
  logic                fifo_push;
  logic [ENTRY_W-1:0]  fifo_in;
  logic [ENTRY_W-1:0]  fifo_head;
  logic                fifo_full;
  logic                fifo_empty;

  // ready_en keeps s_ready low through reset and the first cycle after it.
  // In PH1 the registered full flag gates acceptance, so a pop in the same
  // cycle never raises s_ready combinationally.
  assign s_ready = ready_en && ((state == PH0) || !fifo_full);
  assign accept  = s_valid && s_ready;

  // A beat is lost when it is an orphan beat1, or when a new beat0 arrives
  // while one is already held (the held one is the casualty).
  assign drop_beat = accept && (((state == PH0) && !s_first) ||
                                ((state == PH1) &&  s_first));

  assign fifo_push = accept && (state == PH1) && !s_first;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [2*LANE_W-1:0] lane_ab;
    assign lane_ab = deint_lane(hold[k*LANE_W +: LANE_W], s_data[k*LANE_W +: LANE_W]);
    assign pair_a[k*LANE_W +: LANE_W] = lane_ab[2*LANE_W-1:LANE_W];
    assign pair_b[k*LANE_W +: LANE_W] = lane_ab[LANE_W-1:0];
  end

`ifdef NIBBLE_DEINTERLEAVER_PARITY_EN
  logic beat_perr;
  logic hold_perr;

  // Even parity: s_par must equal the XOR of the data bits.
  assign beat_perr = s_par ^ (^s_data);
  assign fifo_in   = {hold_perr | beat_perr, pair_a, pair_b};

  // Parity status of the held beat0 follows the hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_perr <= 1'b0;
    end else if (accept && s_first) begin
      hold_perr <= beat_perr;
    end
  end
`else
  assign fifo_in = {pair_a, pair_b};
`endif

  // Framing FSM: phase tracking, beat0 hold register and drop counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PH0;
      hold     <= '0;
      ready_en <= 1'b0;
      drop_cnt <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        case (state)
          PH0: begin
            if (s_first) begin
              hold  <= s_data;
              state <= PH1;
            end
          end
          PH1: begin
            if (s_first) begin
              hold <= s_data;
            end else begin
              state <= PH0;
            end
          end
          default: state <= PH0;
        endcase
      end
      if (drop_beat) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  nibble_deinterleaver_fifo2 #(
    .W(ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (m_valid && m_ready),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_valid = !fifo_empty;

`ifdef NIBBLE_DEINTERLEAVER_PARITY_EN
  assign {m_perr, m_a, m_b} = fifo_head;
`else
  assign {m_a, m_b} = fifo_head;
`endif

endmodule

// File: tb/tb_nibble_deinterleaver.sv
// Directed bench for nibble_deinterleaver (LANES=1).
// Table of hand-computed pairs streamed back to back, then hand-written
// sequences for orphans, resync, backpressure, saturation, reset mid-pair
// and (when NIBBLE_DEINTERLEAVER_PARITY_EN is defined) parity flagging.
module tb_nibble_deinterleaver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic       s_first;
  logic [3:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_a;
  logic [3:0] m_b;
  logic [7:0] drop_cnt;
`ifdef NIBBLE_DEINTERLEAVER_PARITY_EN
  logic       s_par;
  logic       m_perr;
  logic       par_flip = 1'b0;
  assign s_par = (^s_data) ^ par_flip;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_deinterleaver #(.LANES(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_first  (s_first),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_a      (m_a),
    .m_b      (m_b),
    .drop_cnt (drop_cnt)
`ifdef NIBBLE_DEINTERLEAVER_PARITY_EN
    ,
    .s_par    (s_par),
    .m_perr   (m_perr)
`endif
  );

  typedef struct {
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] a;
    logic [3:0] b;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_first = 1'b0;
    s_data  = 4'h0;
    rst_n   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [7:0] got [$];
  logic       acc;
  logic       pop;

  initial begin
    tbl[0] = '{d0: 4'h6, d1: 4'h3, a: 4'hA, b: 4'h6};
    tbl[1] = '{d0: 4'h0, d1: 4'h0, a: 4'h0, b: 4'h0};
    tbl[2] = '{d0: 4'hF, d1: 4'hF, a: 4'hF, b: 4'hF};
    tbl[3] = '{d0: 4'hA, d1: 4'h5, a: 4'h3, b: 4'h3};
    tbl[4] = '{d0: 4'h5, d1: 4'hA, a: 4'hC, b: 4'hC};
    tbl[5] = '{d0: 4'h9, d1: 4'h0, a: 4'h1, b: 4'h8};
    tbl[6] = '{d0: 4'h0, d1: 4'hC, a: 4'h4, b: 4'h1};

    // Reset state
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_first = 1'b0;
    s_data  = 4'h0;
    m_ready = 1'b0;
    tick();
    tick();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_a", 32'(m_a), 32'd0);
    check("rst_m_b", 32'(m_b), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    rst_n = 1'b1;
    check("rst_rel_s_ready_low", 32'(s_ready), 32'd0);
    tick();
    check("rst_rel_s_ready_high", 32'(s_ready), 32'd1);

    // Table: pairs streamed back to back with m_ready held high
    m_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_first = 1'b1;
      s_data  = tbl[i].d0;
      check($sformatf("tbl%0d_rdy_b0", i), 32'(s_ready), 32'd1);
      if (i > 0) begin
        check($sformatf("tbl%0d_m_valid", i - 1), 32'(m_valid), 32'd1);
        check($sformatf("tbl%0d_m_a", i - 1), 32'(m_a), 32'(tbl[i-1].a));
        check($sformatf("tbl%0d_m_b", i - 1), 32'(m_b), 32'(tbl[i-1].b));
      end
      tick();
      s_first = 1'b0;
      s_data  = tbl[i].d1;
      check($sformatf("tbl%0d_rdy_b1", i), 32'(s_ready), 32'd1);
      check($sformatf("tbl%0d_gap", i), 32'(m_valid), 32'd0);
      tick();
    end
    s_valid = 1'b0;
    check("tbl6_m_valid", 32'(m_valid), 32'd1);
    check("tbl6_m_a", 32'(m_a), 32'(tbl[6].a));
    check("tbl6_m_b", 32'(m_b), 32'(tbl[6].b));
    check("tbl_drop_cnt", 32'(drop_cnt), 32'd0);
    tick();
    check("tbl_drained", 32'(m_valid), 32'd0);

    // Orphan beat1s
    do_reset();
    s_valid = 1'b1;
    s_first = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_data = 4'(i + 1);
      check($sformatf("orph%0d_rdy", i), 32'(s_ready), 32'd1);
      tick();
    end
    s_valid = 1'b0;
    tick();
    check("orph_m_valid", 32'(m_valid), 32'd0);
    check("orph_drop_cnt", 32'(drop_cnt), 32'd3);

    // Resync: second beat0 replaces the first
    do_reset();
    s_valid = 1'b1;
    s_first = 1'b1;
    s_data  = 4'hF;
    tick();
    s_data = 4'h6;
    check("resync_rdy", 32'(s_ready), 32'd1);
    tick();
    s_first = 1'b0;
    s_data  = 4'h3;
    tick();
    s_valid = 1'b0;
    check("resync_m_valid", 32'(m_valid), 32'd1);
    check("resync_m_a", 32'(m_a), 32'hA);
    check("resync_m_b", 32'(m_b), 32'h6);
    check("resync_drop_cnt", 32'(drop_cnt), 32'd1);
    tick();
    check("resync_single", 32'(m_valid), 32'd0);

    // Backpressure: three pairs into a two-entry buffer
    do_reset();
    m_ready = 1'b0;
    for (int p = 0; p < 2; p++) begin
      s_valid = 1'b1;
      s_first = 1'b1;
      s_data  = tbl[3+p].d0;
      tick();
      s_first = 1'b0;
      s_data  = tbl[3+p].d1;
      tick();
    end
    s_first = 1'b1;
    s_data  = tbl[5].d0;
    check("bp_rdy_ph0_full", 32'(s_ready), 32'd1);
    tick();
    s_first = 1'b0;
    s_data  = tbl[5].d1;
    check("bp_rdy_ph1_full", 32'(s_ready), 32'd0);
    tick();
    check("bp_rdy_stall", 32'(s_ready), 32'd0);
    check("bp_head_a", 32'(m_a), 32'(tbl[3].a));
    m_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      acc = s_valid && s_ready;
      pop = m_valid && m_ready;
      if (pop) got.push_back({m_a, m_b});
      tick();
      if (acc) s_valid = 1'b0;
    end
    check("bp_count", 32'(got.size()), 32'd3);
    for (int p = 0; p < 3; p++) begin
      if (p < got.size()) begin
        check($sformatf("bp_pair%0d", p), 32'(got[p]), 32'({tbl[3+p].a, tbl[3+p].b}));
      end
    end
    check("bp_drop_cnt", 32'(drop_cnt), 32'd0);

    // Saturation of the drop counter
    do_reset();
    s_valid = 1'b1;
    s_first = 1'b0;
    s_data  = 4'h5;
    repeat (254) tick();
    check("sat_254", 32'(drop_cnt), 32'd254);
    tick();
    check("sat_255", 32'(drop_cnt), 32'd255);
    repeat (45) tick();
    check("sat_hold", 32'(drop_cnt), 32'd255);
    s_valid = 1'b0;

    // Reset while beat0 is held: lost and not counted
    do_reset();
    s_valid = 1'b1;
    s_first = 1'b1;
    s_data  = 4'h6;
    tick();
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("midrst_drop_async", 32'(drop_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    s_valid = 1'b1;
    s_first = 1'b0;
    s_data  = 4'h3;
    tick();
    s_valid = 1'b0;
    check("midrst_no_out", 32'(m_valid), 32'd0);
    check("midrst_drop", 32'(drop_cnt), 32'd1);

`ifdef NIBBLE_DEINTERLEAVER_PARITY_EN
    // Parity flag carried with the pair
    do_reset();
    check("par_rst", 32'(m_perr), 32'd0);
    s_valid  = 1'b1;
    s_first  = 1'b1;
    s_data   = 4'h6;
    par_flip = 1'b1;
    tick();
    par_flip = 1'b0;
    s_first  = 1'b0;
    s_data   = 4'h3;
    tick();
    s_first = 1'b1;
    s_data  = 4'h6;
    check("par_bad_valid", 32'(m_valid), 32'd1);
    check("par_bad_perr", 32'(m_perr), 32'd1);
    check("par_bad_a", 32'(m_a), 32'hA);
    tick();
    s_first = 1'b0;
    s_data  = 4'h3;
    tick();
    s_valid = 1'b0;
    check("par_good_valid", 32'(m_valid), 32'd1);
    check("par_good_perr", 32'(m_perr), 32'd0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
